ram_burst_reader: RTL and testbench

Read-side sequencer for simple_dual_port_ram_two_clocks, running in the read-port (CLKB) clock domain. It accepts a burst command (start address, length), drives the RAM read port (ENB/ADDRB), and absorbs the 1-cycle DOB latency. Read data is re-issued as a valid/ready stream with a LAST flag, with full backpressure support and no data loss.

---
 rtl/ram_rd_pkg.sv | 22 ++
 rtl/ram_rd_out_fifo.sv | 74 +++++++
 rtl/ram_burst_reader.sv | 145 ++++++++++++++
 tb/tb_ram_burst_reader.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// rtl/ram_rd_pkg.sv - shared state encoding and sizing helpers for the RAM burst reader
package ram_rd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } rd_state_e;

   // Output buffer depth; also the number of read credits.
   localparam int BUF_DEPTH = 3;

   function automatic int addr_w(input int mem_size);
      return $clog2(mem_size);
   endfunction

   // One extra bit so a full-memory burst length is representable.
   function automatic int len_w(input int mem_size);
      return $clog2(mem_size) + 1;
   endfunction

endpackage

// File: rtl/ram_rd_out_fifo.sv
// rtl/ram_rd_out_fifo.sv - 3-entry synchronous FIFO of {last, data} for the read stream
module ram_rd_out_fifo
   import ram_rd_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic [DW:0] push_entry,
   input  logic        pop,
   output logic [DW:0] head,
   output logic [1:0]  count,
   output logic        empty,
   output logic        full
);

   logic [DW:0] mem_q [BUF_DEPTH];
   logic [DW:0] mem_d [BUF_DEPTH];
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        do_pop;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   // Pointer, occupancy and storage next-state; push and pop together leave occupancy unchanged.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && !empty;
      if (push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      unique case ({push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers; reset empties the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == 2'd0);
   assign full  = (count_q == 2'(BUF_DEPTH));

   // The credit rule upstream makes this unreachable.
   assert property (@(posedge clk) disable iff (rst) !(push && full))
      else $error("ram_rd_out_fifo: push while full");

endmodule

// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read sequencer turning RAM read-port data into a ready/valid stream
module ram_burst_reader
   import ram_rd_pkg::*;
#(
   parameter int DATA_SIZE = 64,
   parameter int MEM_SIZE  = 1024
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          CMD_VALID,
   output logic                          CMD_READY,
   input  logic [addr_w(MEM_SIZE)-1:0]   CMD_ADDR,
   input  logic [len_w(MEM_SIZE)-1:0]    CMD_LEN,
   output logic                          RAM_EN,
   output logic [addr_w(MEM_SIZE)-1:0]   RAM_ADDR,
   input  logic [DATA_SIZE-1:0]          RAM_DO,
   output logic                          M_VALID,
   input  logic                          M_READY,
   output logic [DATA_SIZE-1:0]          M_DATA,
   output logic                          M_LAST,
   output logic                          DONE,
   output logic                          BUSY
);

   localparam int             AW       = addr_w(MEM_SIZE);
   localparam int             LW       = len_w(MEM_SIZE);
   localparam logic [AW-1:0]  ADDR_MAX = AW'(MEM_SIZE - 1);

   rd_state_e         state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [LW-1:0]     rem_q, rem_d;
   logic              ram_en_q, ram_en_d;
   logic [AW-1:0]     ram_addr_q, ram_addr_d;
   logic              ram_last_q, ram_last_d;
   logic              infl_q, infl_d;
   logic              infl_last_q, infl_last_d;
   logic              done_q, done_d;

   logic [DATA_SIZE:0] fifo_head;
   logic [1:0]         fifo_count;
   logic               fifo_empty;
   logic               fifo_full;
   logic               m_pop;
   logic [2:0]         committed;
   logic               credit_ok;

   // Buffered words plus reads still travelling through the RAM; uses registered state only.
   assign committed = {1'b0, fifo_count} + {2'b00, ram_en_q} + {2'b00, infl_q};
   assign credit_ok = (committed < 3'(BUF_DEPTH)) && !fifo_full;
   assign m_pop     = M_VALID && M_READY;

   // FSM next-state, read issue and the two-stage RAM latency pipeline.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      ram_en_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_last_d  = 1'b0;
      done_d      = 1'b0;
      infl_d      = ram_en_q;
      infl_last_d = ram_last_q;
      unique case (state_q)
         ST_IDLE: begin
            if (CMD_VALID) begin
               addr_d = CMD_ADDR;
               rem_d  = CMD_LEN;
               if (CMD_LEN == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (credit_ok) begin
               ram_en_d   = 1'b1;
               ram_addr_d = addr_q;
               ram_last_d = (rem_q == LW'(1));
               addr_d     = (addr_q == ADDR_MAX) ? '0 : addr_q + AW'(1);
               rem_d      = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (m_pop && M_LAST) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and pipeline registers; reset aborts any burst and drops in-flight reads.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         ram_en_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_last_q  <= 1'b0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         ram_en_q    <= ram_en_d;
         ram_addr_q  <= ram_addr_d;
         ram_last_q  <= ram_last_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         done_q      <= done_d;
      end
   end

   ram_rd_out_fifo #(
      .DW(DATA_SIZE)
   ) u_out_fifo (
      .clk        (CLK),
      .rst        (RST),
      .push       (infl_q),
      .push_entry ({infl_last_q, RAM_DO}),
      .pop        (m_pop),
      .head       (fifo_head),
      .count      (fifo_count),
      .empty      (fifo_empty),
      .full       (fifo_full)
   );

   assign CMD_READY = (state_q == ST_IDLE);
   assign BUSY      = (state_q != ST_IDLE);
   assign RAM_EN    = ram_en_q;
   assign RAM_ADDR  = ram_addr_q;
   assign M_VALID   = !fifo_empty;
   assign M_DATA    = fifo_head[DATA_SIZE-1:0];
   assign M_LAST    = M_VALID && fifo_head[DATA_SIZE];
   assign DONE      = done_q;

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - directed self-checking bench for ram_burst_reader
module tb_ram_burst_reader;

   localparam int DW = 64;
   localparam int MS = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [9:0]    cmd_addr;
   logic [10:0]   cmd_len;
   logic          ram_en;
   logic [9:0]    ram_addr;
   logic [DW-1:0] ram_do;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          done;
   logic          busy;

   logic [DW-1:0] mem [MS];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [DW-1:0] data_q [$];
   logic          last_q [$];
   logic [9:0]    raddr_q [$];
   int issued, hs, max_out, stab_err, done_n, done_cyc, acc_n, accept_cyc;
   int first_valid_cyc, valid_seen, hs_cyc, seed_dummy;
   logic          stall_prev;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   ram_burst_reader #(
      .DATA_SIZE(DW),
      .MEM_SIZE (MS)
   ) dut (
      .CLK       (clk),
      .RST       (rst),
      .CMD_VALID (cmd_valid),
      .CMD_READY (cmd_ready),
      .CMD_ADDR  (cmd_addr),
      .CMD_LEN   (cmd_len),
      .RAM_EN    (ram_en),
      .RAM_ADDR  (ram_addr),
      .RAM_DO    (ram_do),
      .M_VALID   (m_valid),
      .M_READY   (m_ready),
      .M_DATA    (m_data),
      .M_LAST    (m_last),
      .DONE      (done),
      .BUSY      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // RAM read port: one-cycle registered read, DOB holds while ENB is low.
   always @(posedge clk) if (ram_en) ram_do <= mem[ram_addr];

   // Monitor sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_valid && cmd_ready) begin
            acc_n++;
            accept_cyc = cyc;
         end
         if (ram_en) begin
            raddr_q.push_back(ram_addr);
            issued++;
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid) valid_seen++;
         if (stall_prev && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
         stall_prev = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (issued - hs > max_out) max_out = issued - hs;
         if (m_valid && m_ready) begin
            data_q.push_back(m_data);
            last_q.push_back(m_last);
            hs_cyc = cyc;
            hs++;
         end
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      data_q.delete();
      last_q.delete();
      raddr_q.delete();
      issued = 0; hs = 0; max_out = 0; stab_err = 0; done_n = 0; done_cyc = -1;
      acc_n = 0; accept_cyc = -1; first_valid_cyc = -1; valid_seen = 0; hs_cyc = -1;
      stall_prev = 1'b0;
   endtask

   task automatic run_cmd(input int addr, input int len);
      int base;
      base      = acc_n;
      cmd_addr  = 10'(addr);
      cmd_len   = 11'(len);
      cmd_valid = 1'b1;
      for (int i = 0; i < 200 && acc_n == base; i++) step();
      cmd_valid = 1'b0;
      check("cmd_accepted", 64'(acc_n > base), 64'd1);
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int i = 0; i < budget && done_n < n; i++) step();
      check("done_seen", 64'(done_n >= n), 64'd1);
   endtask

   task automatic check_word(input int idx, input int exp, input logic exp_last);
      if (idx < data_q.size()) begin
         check($sformatf("data[%0d]", idx), data_q[idx], 64'(exp));
         check($sformatf("last[%0d]", idx), 64'(last_q[idx]), 64'(exp_last));
      end else begin
         check($sformatf("word_present[%0d]", idx), 64'd0, 64'd1);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_ram_en"},    64'(ram_en),    64'd0);
      check({tag, "_ram_addr"},  64'(ram_addr),  64'd0);
      check({tag, "_m_valid"},   64'(m_valid),   64'd0);
      check({tag, "_m_last"},    64'(m_last),    64'd0);
      check({tag, "_done"},      64'(done),      64'd0);
      check({tag, "_busy"},      64'(busy),      64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;
      m_ready   = 1'b0;
      ram_do    = '0;
      for (int i = 0; i < MS; i++) mem[i] = 64'(i);
      clear_log();
      repeat (3) step();
      rst = 1'b0;
      step();
      check_idle_outputs("reset");

      // Basic burst with M_READY held high.
      clear_log();
      m_ready = 1'b1;
      run_cmd(10, 4);
      wait_done(1, 100);
      repeat (3) step();
      check("t1_count", 64'(data_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) check_word(i, 10 + i, i == 3);
      check("t1_first_valid_lat", 64'(first_valid_cyc - accept_cyc), 64'd4);
      check("t1_done_after_last", 64'(done_cyc - hs_cyc), 64'd1);
      check("t1_done_pulses", 64'(done_n), 64'd1);
      check("t1_credit", 64'(max_out <= 3), 64'd1);

      // Address wrap at the top of memory.
      clear_log();
      run_cmd(1022, 4);
      wait_done(1, 100);
      check("t2_raddr_count", 64'(raddr_q.size()), 64'd4);
      if (raddr_q.size() == 4) begin
         check("t2_raddr0", 64'(raddr_q[0]), 64'd1022);
         check("t2_raddr1", 64'(raddr_q[1]), 64'd1023);
         check("t2_raddr2", 64'(raddr_q[2]), 64'd0);
         check("t2_raddr3", 64'(raddr_q[3]), 64'd1);
      end
      check_word(0, 1022, 1'b0);
      check_word(1, 1023, 1'b0);
      check_word(2, 0, 1'b0);
      check_word(3, 1, 1'b1);

      // Random backpressure with a 20-cycle stall.
      clear_log();
      m_ready    = 1'b0;
      seed_dummy = $urandom(1);
      run_cmd(0, 16);
      for (int k = 0; k < 600 && done_n == 0; k++) begin
         step();
         m_ready = (k >= 4 && k < 24) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      check("t3_done", 64'(done_n), 64'd1);
      check("t3_count", 64'(data_q.size()), 64'd16);
      for (int i = 0; i < 16; i++) check_word(i, i, i == 15);
      check("t3_stable", 64'(stab_err), 64'd0);
      check("t3_credit", 64'(max_out <= 3), 64'd1);
      m_ready = 1'b1;

      // Zero-length command.
      clear_log();
      run_cmd(0, 0);
      check("t4_done_now", 64'(done), 64'd1);
      check("t4_ready_now", 64'(cmd_ready), 64'd1);
      step();
      check("t4_done_lat", 64'(done_cyc - accept_cyc), 64'd1);
      check("t4_ready_next", 64'(cmd_ready), 64'd1);
      check("t4_done_low", 64'(done), 64'd0);
      step();
      check("t4_no_ram_en", 64'(raddr_q.size()), 64'd0);
      check("t4_no_valid", 64'(valid_seen), 64'd0);

      // Reset in the middle of a burst.
      clear_log();
      run_cmd(0, 8);
      for (int i = 0; i < 50 && hs < 3; i++) step();
      check("t5_three_words", 64'(hs >= 3), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_idle_outputs("t5_after_rst");
      clear_log();
      repeat (10) step();
      check("t5_no_done", 64'(done_n), 64'd0);
      check("t5_no_valid", 64'(valid_seen), 64'd0);
      check("t5_no_ram_en", 64'(raddr_q.size()), 64'd0);
      run_cmd(100, 2);
      wait_done(1, 100);
      repeat (3) step();
      check("t5_count", 64'(data_q.size()), 64'd2);
      check_word(0, 100, 1'b0);
      check_word(1, 101, 1'b1);

      // Command presented while busy waits for DONE.
      clear_log();
      m_ready = 1'b0;
      run_cmd(0, 2);
      cmd_addr  = 10'd50;
      cmd_len   = 11'd1;
      cmd_valid = 1'b1;
      repeat (6) step();
      check("t6_ready_low", 64'(cmd_ready), 64'd0);
      check("t6_not_accepted", 64'(acc_n), 64'd1);
      m_ready = 1'b1;
      for (int i = 0; i < 100 && acc_n < 2; i++) step();
      cmd_valid = 1'b0;
      check("t6_accept_in_done", 64'(accept_cyc), 64'(done_cyc));
      wait_done(2, 100);
      check("t6_count", 64'(data_q.size()), 64'd3);
      check_word(0, 0, 1'b0);
      check_word(1, 1, 1'b1);
      check_word(2, 50, 1'b1);
      check("t6_stable", 64'(stab_err), 64'd0);

      // Back-to-back bursts.
      clear_log();
      run_cmd(0, 2);
      cmd_addr  = 10'd5;
      cmd_len   = 11'd2;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100 && acc_n < 2; i++) step();
      cmd_valid = 1'b0;
      wait_done(2, 100);
      check("t6b_count", 64'(data_q.size()), 64'd4);
      check_word(0, 0, 1'b0);
      check_word(1, 1, 1'b1);
      check_word(2, 5, 1'b0);
      check_word(3, 6, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
